// File: rtl/iter_rect.sv
// Row-major raster iterator for filled or outlined axis-aligned rectangles,
// clipped to the screen, with the start/oe/busy/done render-iterator handshake.
module iter_rect #(
    parameter int unsigned CORDW = 10,
    parameter int unsigned SCR_W = 640,
    parameter int unsigned SCR_H = 480
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             oe,
    input  logic             abort,
    input  logic             mode,
    input  logic [CORDW-1:0] x0,
    input  logic [CORDW-1:0] y0,
    input  logic [CORDW-1:0] w,
    input  logic [CORDW-1:0] h,
    output logic [CORDW-1:0] x,
    output logic [CORDW-1:0] y,
    output logic             drawing,
    output logic             busy,
    output logic             done
);

    typedef enum logic {IDLE, DRAW} state_t;

    localparam logic [CORDW:0] SCR_W_L = (CORDW+1)'(SCR_W);
    localparam logic [CORDW:0] SCR_H_L = (CORDW+1)'(SCR_H);
    localparam logic [CORDW:0] ONE     = (CORDW+1)'(1);

    state_t           state;
    logic [CORDW-1:0] xs, ys;
    logic [CORDW:0]   xe, ye, xr, yb;
    logic             outline;

    logic [CORDW:0]   sum_x, sum_y, xe_n, ye_n;
    logic             empty;

    logic [CORDW:0]   x_inc, y_inc;
    logic             interior, jump_right, last;
    logic [CORDW-1:0] x_nxt, y_nxt;

    // Bounds are one bit wider than coordinates so x0+w never wraps.
    always_comb begin
        sum_x = {1'b0, x0} + {1'b0, w};
        sum_y = {1'b0, y0} + {1'b0, h};
        xe_n  = (sum_x < SCR_W_L) ? sum_x : SCR_W_L;
        ye_n  = (sum_y < SCR_H_L) ? sum_y : SCR_H_L;
        empty = (w == '0) || (h == '0) ||
                ({1'b0, x0} >= SCR_W_L) || ({1'b0, y0} >= SCR_H_L);
    end

    // Interior outline rows visit only the left edge and, if on-screen, the right edge.
    always_comb begin
        x_inc      = {1'b0, x} + ONE;
        y_inc      = {1'b0, y} + ONE;
        interior   = outline && (y != ys) && ({1'b0, y} != yb);
        jump_right = interior && (x == xs) && (xr < xe) && (xr != {1'b0, xs});
        x_nxt      = x;
        y_nxt      = y;
        last       = 1'b0;
        if (jump_right) begin
            x_nxt = xr[CORDW-1:0];
        end else if (!interior && (x_inc < xe)) begin
            x_nxt = x_inc[CORDW-1:0];
        end else if (y_inc < ye) begin
            x_nxt = xs;
            y_nxt = y_inc[CORDW-1:0];
        end else begin
            last = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            x       <= '0;
            y       <= '0;
            xs      <= '0;
            ys      <= '0;
            xe      <= '0;
            ye      <= '0;
            xr      <= '0;
            yb      <= '0;
            outline <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (empty) begin
                            done <= 1'b1;
                        end else begin
                            state   <= DRAW;
                            busy    <= 1'b1;
                            x       <= x0;
                            y       <= y0;
                            xs      <= x0;
                            ys      <= y0;
                            xe      <= xe_n;
                            ye      <= ye_n;
                            xr      <= sum_x - ONE;
                            yb      <= sum_y - ONE;
                            outline <= mode;
                        end
                    end
                end
                DRAW: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (oe) begin
                        if (last) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            x <= x_nxt;
                            y <= y_nxt;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign drawing = (state == DRAW) && oe;

endmodule

// File: tb/tb_iter_rect.sv
// Self-checking bench for iter_rect: directed scenarios plus randomized
// rectangles compared against a set-based pixel model.
module tb_iter_rect;

    localparam int SCR_W = 640;
    localparam int SCR_H = 480;

    logic       clk = 1'b0;
    logic       rst, start, oe, abort, mode;
    logic [9:0] x0, y0, w, h, x, y;
    logic       drawing, busy, done;

    int errors = 0;
    int checks = 0;

    int exp_x[$], exp_y[$], obs_x[$], obs_y[$];
    int first_cycle, last_cycle, done_cycle;
    int busy_seen, busy_err, hold_err;
    int post_busy, post_done, post_draw;

    iter_rect #(.CORDW(10), .SCR_W(SCR_W), .SCR_H(SCR_H)) dut (
        .clk(clk), .rst(rst), .start(start), .oe(oe), .abort(abort), .mode(mode),
        .x0(x0), .y0(y0), .w(w), .h(h),
        .x(x), .y(y), .drawing(drawing), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Expected pixels: every on-screen pixel of the rectangle, filtered to the
    // border when outlining, listed row-major.
    task automatic build_model(input bit m, input int ax, input int ay, input int aw, input int ah);
        exp_x.delete();
        exp_y.delete();
        for (int yy = ay; yy < ay + ah && yy < SCR_H; yy++)
            for (int xx = ax; xx < ax + aw && xx < SCR_W; xx++)
                if (!m || yy == ay || yy == ay + ah - 1 || xx == ax || xx == ax + aw - 1) begin
                    exp_x.push_back(xx);
                    exp_y.push_back(yy);
                end
    endtask

    function automatic int first_diff();
        int n;
        n = (obs_x.size() < exp_x.size()) ? obs_x.size() : exp_x.size();
        for (int i = 0; i < n; i++)
            if (obs_x[i] != exp_x[i] || obs_y[i] != exp_y[i]) return i;
        if (obs_x.size() != exp_x.size()) return n;
        return -1;
    endfunction

    task automatic start_rect(input bit m, input int ax, input int ay, input int aw, input int ah);
        @(negedge clk);
        mode  = m;
        x0    = 10'(ax);
        y0    = 10'(ay);
        w     = 10'(aw);
        h     = 10'(ah);
        start = 1'b1;
        abort = 1'b0;
        oe    = 1'b1;
    endtask

    // Samples one cycle per iteration; oe_mode 0 = always on, 1 = random, 2 = 1,0,0,1,...
    task automatic collect(input int max_cycles, input int oe_mode, input int abort_at, input bit hold);
        logic [9:0] px, py;
        bit prev_stall, aborted;
        obs_x.delete();
        obs_y.delete();
        first_cycle = -1; last_cycle = -1; done_cycle = -1;
        busy_seen = 0; busy_err = 0; hold_err = 0;
        post_busy = -1; post_done = -1; post_draw = -1;
        prev_stall = 1'b0; aborted = 1'b0; px = '0; py = '0;
        for (int c = 1; c <= max_cycles; c++) begin
            @(negedge clk);
            start = hold;
            case (oe_mode)
                0:       oe = 1'b1;
                1:       oe = ($urandom_range(0, 2) != 0);
                default: oe = !(c == 2 || c == 3);
            endcase
            abort = (abort_at > 0 && !aborted && obs_x.size() == abort_at - 1);
            #1;
            if (prev_stall && (x !== px || y !== py)) hold_err++;
            prev_stall = busy && !oe;
            px = x;
            py = y;
            if (busy) busy_seen++;
            if (drawing) begin
                obs_x.push_back(int'(x));
                obs_y.push_back(int'(y));
                if (first_cycle < 0) first_cycle = c;
                last_cycle = c;
                if (!busy) busy_err++;
            end
            if (aborted) begin
                post_busy = busy;
                post_done = done;
                post_draw = drawing;
                break;
            end
            if (abort && drawing) aborted = 1'b1;
            if (done) begin
                done_cycle = c;
                break;
            end
        end
        abort = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b1; oe = 1'b1; abort = 1'b0; mode = 1'b0;
        x0 = 10'd5; y0 = 10'd5; w = 10'd3; h = 10'd3;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0)    begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0)    begin errors++; $display("[TB] FAIL reset_done: got %b want 0", done); end
        checks++; if (drawing !== 1'b0) begin errors++; $display("[TB] FAIL reset_drawing: got %b want 0", drawing); end
        checks++; if (x !== 10'd0 || y !== 10'd0) begin errors++; $display("[TB] FAIL reset_xy: got (%0d,%0d) want (0,0)", x, y); end
        rst = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_fill();
        int ex[6] = '{2, 3, 4, 2, 3, 4};
        int ey[6] = '{3, 3, 3, 4, 4, 4};
        int bad;
        start_rect(1'b0, 2, 3, 3, 2);
        collect(40, 0, 0, 1'b0);
        bad = (obs_x.size() != 6);
        for (int i = 0; i < 6 && !bad; i++) if (obs_x[i] != ex[i] || obs_y[i] != ey[i]) bad = 1;
        checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL fill_pixels: got %0d px, want the 6 listed pixels in order", obs_x.size()); end
        checks++; if (first_cycle !== 1) begin errors++; $display("[TB] FAIL fill_first: got cycle %0d want 1", first_cycle); end
        checks++; if (done_cycle !== 7)  begin errors++; $display("[TB] FAIL fill_done: got cycle %0d want 7", done_cycle); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("[TB] FAIL fill_busy_at_done: got %b want 0", busy); end
        @(negedge clk);
        #1;
        checks++; if (done !== 1'b0)     begin errors++; $display("[TB] FAIL fill_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_outline();
        start_rect(1'b1, 0, 0, 4, 3);
        collect(40, 0, 0, 1'b0);
        build_model(1'b1, 0, 0, 4, 3);
        checks++; if (obs_x.size() !== 10) begin errors++; $display("[TB] FAIL outline_count: got %0d want 10", obs_x.size()); end
        checks++; if (first_diff() !== -1) begin errors++; $display("[TB] FAIL outline_order: first diff at %0d want -1", first_diff()); end
    endtask

    task automatic test_clip();
        int off;
        start_rect(1'b0, 638, 478, 5, 5);
        collect(40, 0, 0, 1'b0);
        build_model(1'b0, 638, 478, 5, 5);
        checks++; if (obs_x.size() !== 4)  begin errors++; $display("[TB] FAIL clip_fill_count: got %0d want 4", obs_x.size()); end
        checks++; if (first_diff() !== -1) begin errors++; $display("[TB] FAIL clip_fill_order: first diff at %0d want -1", first_diff()); end
        checks++; if (done_cycle !== 5)    begin errors++; $display("[TB] FAIL clip_fill_done: got cycle %0d want 5", done_cycle); end
        // Row 479 is interior here, so only its left edge survives; x=642 is off-screen.
        start_rect(1'b1, 638, 478, 5, 5);
        collect(40, 0, 0, 1'b0);
        build_model(1'b1, 638, 478, 5, 5);
        off = 0;
        foreach (obs_x[i]) if (obs_x[i] >= SCR_W || obs_y[i] >= SCR_H) off++;
        checks++; if (off !== 0)           begin errors++; $display("[TB] FAIL clip_outline_offscreen: got %0d px want 0", off); end
        checks++; if (first_diff() !== -1) begin errors++; $display("[TB] FAIL clip_outline_order: first diff at %0d want -1", first_diff()); end
    endtask

    task automatic test_empty();
        int cases[3][4] = '{'{5, 5, 0, 4}, '{5, 5, 4, 0}, '{640, 5, 4, 4}};
        for (int k = 0; k < 3; k++) begin
            start_rect(1'b0, cases[k][0], cases[k][1], cases[k][2], cases[k][3]);
            collect(5, 0, 0, 1'b0);
            checks++;
            if (done_cycle !== 1 || busy_seen !== 0 || obs_x.size() !== 0) begin
                errors++;
                $display("[TB] FAIL empty_%0d: done cycle %0d busy %0d px %0d, want 1/0/0", k, done_cycle, busy_seen, obs_x.size());
            end
        end
    endtask

    task automatic test_stall();
        start_rect(1'b0, 7, 9, 2, 2);
        collect(40, 2, 0, 1'b0);
        build_model(1'b0, 7, 9, 2, 2);
        checks++; if (first_diff() !== -1) begin errors++; $display("[TB] FAIL stall_order: first diff at %0d want -1", first_diff()); end
        checks++; if (hold_err !== 0)      begin errors++; $display("[TB] FAIL stall_hold: got %0d moves want 0", hold_err); end
        checks++; if (done_cycle !== last_cycle + 1) begin errors++; $display("[TB] FAIL stall_done: got cycle %0d want %0d", done_cycle, last_cycle + 1); end
    endtask

    task automatic test_abort();
        start_rect(1'b0, 10, 20, 4, 4);
        collect(40, 0, 3, 1'b0);
        checks++; if (obs_x.size() !== 3) begin errors++; $display("[TB] FAIL abort_count: got %0d want 3", obs_x.size()); end
        checks++;
        if (post_busy !== 0 || post_done !== 0 || post_draw !== 0) begin
            errors++;
            $display("[TB] FAIL abort_after: busy %0d done %0d drawing %0d want 0/0/0", post_busy, post_done, post_draw);
        end
        start_rect(1'b0, 1, 1, 2, 1);
        collect(40, 0, 0, 1'b0);
        build_model(1'b0, 1, 1, 2, 1);
        checks++; if (first_diff() !== -1 || done_cycle !== 3) begin errors++; $display("[TB] FAIL abort_restart: diff %0d done %0d want -1/3", first_diff(), done_cycle); end
    endtask

    task automatic test_reset_mid();
        int seen;
        start_rect(1'b0, 5, 6, 4, 4);
        repeat (3) begin
            @(negedge clk);
            start = 1'b0;
            oe = 1'b1;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || drawing !== 1'b0 || x !== 10'd0 || y !== 10'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid: busy %b done %b drawing %b xy (%0d,%0d) want all 0", busy, done, drawing, x, y);
        end
        rst = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            #1;
            if (done || busy) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL reset_mid_quiet: got %0d active cycles want 0", seen); end
    endtask

    task automatic test_back_to_back();
        start_rect(1'b0, 0, 0, 3, 2);
        @(posedge clk);
        #1;
        mode = 1'b1; x0 = 10'd100; y0 = 10'd50; w = 10'd3; h = 10'd3;
        collect(40, 0, 0, 1'b1);
        build_model(1'b0, 0, 0, 3, 2);
        checks++; if (first_diff() !== -1 || done_cycle !== 7) begin errors++; $display("[TB] FAIL b2b_first: diff %0d done %0d want -1/7", first_diff(), done_cycle); end
        collect(40, 0, 0, 1'b0);
        build_model(1'b1, 100, 50, 3, 3);
        checks++; if (first_cycle !== 1)   begin errors++; $display("[TB] FAIL b2b_latency: got cycle %0d want 1", first_cycle); end
        checks++; if (first_diff() !== -1) begin errors++; $display("[TB] FAIL b2b_second: first diff at %0d want -1", first_diff()); end
    endtask

    task automatic test_random();
        int m, ax, ay, aw, ah;
        for (int n = 0; n < 30; n++) begin
            m  = $urandom_range(0, 1);
            aw = $urandom_range(0, 6);
            ah = $urandom_range(0, 6);
            ax = $urandom_range(0, 1) ? $urandom_range(634, 645) : $urandom_range(0, 50);
            ay = $urandom_range(0, 1) ? $urandom_range(474, 485) : $urandom_range(0, 50);
            start_rect(m[0], ax, ay, aw, ah);
            collect(300, 1, 0, 1'b0);
            build_model(m[0], ax, ay, aw, ah);
            checks++;
            if (first_diff() !== -1) begin
                errors++;
                $display("[TB] FAIL rand_%0d_pixels: m%0d (%0d,%0d) %0dx%0d diff at %0d want -1", n, m, ax, ay, aw, ah, first_diff());
            end
            checks++;
            if (done_cycle !== ((exp_x.size() == 0) ? 1 : last_cycle + 1) || busy_err !== 0) begin
                errors++;
                $display("[TB] FAIL rand_%0d_done: done cycle %0d last px %0d busy_err %0d", n, done_cycle, last_cycle, busy_err);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; oe = 1'b0; abort = 1'b0; mode = 1'b0;
        x0 = '0; y0 = '0; w = '0; h = '0;
        test_reset();
        test_fill();
        test_outline();
        test_clip();
        test_empty();
        test_stall();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
